// File: rtl/match_count_disp_if.sv
// Bus for the match counter / display block: detector-side inputs and
// board-side outputs. The master drives the detector side and observes the
// board side; the slave is the counter/display block itself.
interface match_count_disp_if;
  logic       tick_en;
  logic       match_in;
  logic       clr;
  logic [7:0] count_bcd;
  logic       ovf;
  logic       hit_led;
  logic [7:0] seg;
  logic [1:0] dig_sel;

  modport master (
    output tick_en,
    output match_in,
    output clr,
    input  count_bcd,
    input  ovf,
    input  hit_led,
    input  seg,
    input  dig_sel
  );

  modport slave (
    input  tick_en,
    input  match_in,
    input  clr,
    output count_bcd,
    output ovf,
    output hit_led,
    output seg,
    output dig_sel
  );
endinterface

// File: rtl/match_count_disp.sv
// Counts 11010-detector matches as a 2-digit BCD value, stretches each
// detection into a visible LED pulse and scans the count onto a 2-digit
// multiplexed, active-low 7-segment display.
module match_count_disp #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  match_count_disp_if.slave  bus
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_TICKS);

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_e;

  // Active-low segment pattern for one decimal digit, dp off; anything that
  // is not a BCD digit is shown blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  logic              match_prev_q, match_prev_d;
  logic [7:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        hold_q, hold_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  digit_e            digit_q, digit_d;
  logic [1:0]        dig_sel_q, dig_sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              det_event;

  // A detection is a rising edge of the match level as seen at tick rate only.
  always_comb begin
    det_event    = bus.tick_en && bus.match_in && !match_prev_q;
    match_prev_d = match_prev_q;
    if (bus.tick_en) begin
      match_prev_d = bus.match_in;
    end
  end

  // BCD counter with sticky wrap flag; clear wins and swallows a same-cycle event.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      count_d = 8'h00;
      ovf_d   = 1'b0;
    end else if (det_event) begin
      if (count_q[3:0] == 4'd9) begin
        count_d[3:0] = 4'd0;
        if (count_q[7:4] == 4'd9) begin
          count_d[7:4] = 4'd0;
          ovf_d        = 1'b1;
        end else begin
          count_d[7:4] = count_q[7:4] + 4'd1;
        end
      end else begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end
    end
  end

  // LED stretch: a detection (re)loads the hold count, ticks drain it.
  always_comb begin
    hold_d = hold_q;
    if (det_event) begin
      hold_d = HOLD_LOAD;
    end else if (bus.tick_en && (hold_q != 4'd0)) begin
      hold_d = hold_q - 4'd1;
    end
  end

  // Digit scan: on each slot boundary switch digit and latch its pattern from
  // the registered count, so both digits come from one consistent snapshot.
  always_comb begin
    scan_d    = scan_q + SCAN_W'(1);
    digit_d   = digit_q;
    dig_sel_d = dig_sel_q;
    seg_d     = seg_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      if (digit_q == DIG_ONES) begin
        digit_d   = DIG_TENS;
        dig_sel_d = 2'b01;
        seg_d     = (count_q[7:4] == 4'd0) ? 8'hFF : seg_decode(count_q[7:4]);
      end else begin
        digit_d   = DIG_ONES;
        dig_sel_d = 2'b10;
        seg_d     = seg_decode(count_q[3:0]);
      end
    end
  end

  // State registers; reset shows the ones digit '0'.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_prev_q <= 1'b0;
      count_q      <= 8'h00;
      ovf_q        <= 1'b0;
      hold_q       <= 4'd0;
      scan_q       <= '0;
      digit_q      <= DIG_ONES;
      dig_sel_q    <= 2'b10;
      seg_q        <= 8'hC0;
    end else begin
      match_prev_q <= match_prev_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      hold_q       <= hold_d;
      scan_q       <= scan_d;
      digit_q      <= digit_d;
      dig_sel_q    <= dig_sel_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.hit_led   = (hold_q != 4'd0);
  assign bus.seg       = seg_q;
  assign bus.dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_match_count_disp.sv
// Self-checking bench for match_count_disp: a reference model predicts
// {count_bcd, ovf, hit_led} per cycle into a queue, each test pops and compares.
module tb_match_count_disp;

  localparam int SCAN_DIV   = 4;
  localparam int HOLD_TICKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  match_count_disp_if bus();

  match_count_disp #(
    .SCAN_DIV   (SCAN_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];
  int m_cnt  = 0;
  int m_hold = 0;
  bit m_prev = 1'b0;
  bit m_ovf  = 1'b0;

  // Drive one cycle of inputs, advance the model, push its prediction, clock.
  task automatic drive_step(input bit tick, input bit match, input bit clear);
    bit ev;
    logic [7:0] bcd;
    bus.tick_en  = tick;
    bus.match_in = match;
    bus.clr      = clear;
    ev = tick && match && !m_prev;
    if (tick) m_prev = match;
    if (clear) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (ev) begin
      if (m_cnt == 99) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (ev) m_hold = HOLD_TICKS;
    else if (tick && m_hold != 0) m_hold = m_hold - 1;
    bcd = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    exp_q.push_back({bcd, m_ovf, (m_hold != 0)});
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, model and queue cleared to match.
  task automatic do_reset();
    rst = 1'b1;
    bus.tick_en  = 1'b1;
    bus.match_in = 1'b0;
    bus.clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0; m_hold = 0; m_prev = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    rst = 1'b1;
    bus.tick_en  = 1'b1;
    bus.match_in = 1'b1;
    bus.clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.count_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_count got %h want 00", bus.count_bcd); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    n_checks++; if (bus.hit_led !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", bus.hit_led); end
    n_checks++; if (bus.dig_sel !== 2'b10) begin n_fail++; $display("FAIL reset_digsel got %b want 10", bus.dig_sel); end
    n_checks++; if (bus.seg !== 8'hC0) begin n_fail++; $display("FAIL reset_seg got %h want C0", bus.seg); end
    rst = 1'b0;
    m_cnt = 0; m_hold = 0; m_prev = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    drive_step(1'b1, 1'b1, 1'b0);
    got = {bus.count_bcd, bus.ovf, bus.hit_led};
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL reset_release cnt/ovf/hit got %h want %h", got, exp); end
    n_checks++; if (bus.count_bcd !== 8'h01) begin n_fail++; $display("FAIL reset_first_tick got %h want 01", bus.count_bcd); end
  endtask

  task automatic test_pulse_count();
    logic [9:0] got, exp;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 6; c++) begin
        drive_step(1'b1, (c == 0), 1'b0);
        got = {bus.count_bcd, bus.ovf, bus.hit_led};
        exp = exp_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pulse p%0d c%0d got %h want %h", p, c, got, exp); end
      end
    end
    for (int c = 0; c < 10; c++) begin
      drive_step(1'b1, (c < 5), 1'b0);
      got = {bus.count_bcd, bus.ovf, bus.hit_led};
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL held_level c%0d got %h want %h", c, got, exp); end
    end
    n_checks++; if (bus.count_bcd !== 8'h04) begin n_fail++; $display("FAIL held_once got %h want 04", bus.count_bcd); end
  endtask

  task automatic test_carry_wrap();
    logic [9:0] got, exp;
    do_reset();
    for (int e = 1; e <= 100; e++) begin
      for (int c = 0; c < 2; c++) begin
        drive_step(1'b1, (c == 0), 1'b0);
        got = {bus.count_bcd, bus.ovf, bus.hit_led};
        exp = exp_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL carry e%0d c%0d got %h want %h", e, c, got, exp); end
      end
      if (e == 10) begin
        n_checks++; if (bus.count_bcd !== 8'h10) begin n_fail++; $display("FAIL carry_10 got %h want 10", bus.count_bcd); end
      end
      if (e == 99) begin
        n_checks++; if (bus.count_bcd !== 8'h99 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL at_99 got %h/%b want 99/0", bus.count_bcd, bus.ovf); end
      end
    end
    n_checks++; if (bus.count_bcd !== 8'h00 || bus.ovf !== 1'b1) begin n_fail++; $display("FAIL wrap got %h/%b want 00/1", bus.count_bcd, bus.ovf); end
    drive_step(1'b1, 1'b0, 1'b1);
    got = {bus.count_bcd, bus.ovf, bus.hit_led};
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL clr got %h want %h", got, exp); end
    drive_step(1'b1, 1'b1, 1'b0);
    got = {bus.count_bcd, bus.ovf, bus.hit_led};
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pre_clr_event got %h want %h", got, exp); end
    drive_step(1'b1, 1'b0, 1'b0);
    got = {bus.count_bcd, bus.ovf, bus.hit_led};
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pre_clr_idle got %h want %h", got, exp); end
    drive_step(1'b1, 1'b1, 1'b1);
    got = {bus.count_bcd, bus.ovf, bus.hit_led};
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL clr_vs_event got %h want %h", got, exp); end
    n_checks++; if (bus.count_bcd !== 8'h00) begin n_fail++; $display("FAIL clr_priority got %h want 00", bus.count_bcd); end
  endtask

  task automatic test_tick_gating();
    logic [9:0] got, exp;
    bit m;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      m = (c == 1) || (c == 2) || (c == 7) || (c == 8) || (c == 19) || (c == 20);
      drive_step((c % 4) == 0, m, 1'b0);
      got = {bus.count_bcd, bus.ovf, bus.hit_led};
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tick_gate c%0d got %h want %h", c, got, exp); end
    end
    n_checks++; if (bus.count_bcd !== 8'h02) begin n_fail++; $display("FAIL tick_gate_total got %h want 02", bus.count_bcd); end
  endtask

  task automatic test_display();
    logic [9:0] got, exp;
    logic [1:0] prev;
    int run;
    bit first;
    do_reset();
    for (int c = 0; c < 102; c++) begin
      drive_step(1'b1, (c < 94) && ((c % 2) == 0), 1'b0);
      got = {bus.count_bcd, bus.ovf, bus.hit_led};
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL disp_load c%0d got %h want %h", c, got, exp); end
    end
    prev = bus.dig_sel; run = 0; first = 1'b1;
    for (int c = 0; c < 24; c++) begin
      drive_step(1'b1, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      if (bus.dig_sel != prev) begin
        if (!first) begin
          n_checks++; if (run != SCAN_DIV) begin n_fail++; $display("FAIL scan_period got %0d want %0d", run, SCAN_DIV); end
        end
        first = 1'b0; run = 1; prev = bus.dig_sel;
      end else begin
        run++;
      end
      n_checks++;
      if (!((bus.dig_sel == 2'b10 && bus.seg == 8'hF8) || (bus.dig_sel == 2'b01 && bus.seg == 8'h99))) begin
        n_fail++; $display("FAIL disp_47 c%0d dig_sel/seg got %b/%h want 10/F8 or 01/99", c, bus.dig_sel, bus.seg);
      end
    end
    drive_step(1'b1, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    for (int c = 0; c < 18; c++) begin
      drive_step(1'b1, (c < 10) && ((c % 2) == 0), 1'b0);
      exp = exp_q.pop_front();
    end
    n_checks++; if (bus.count_bcd !== 8'h05) begin n_fail++; $display("FAIL disp_05_count got %h want 05", bus.count_bcd); end
    for (int c = 0; c < 16; c++) begin
      drive_step(1'b1, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      n_checks++;
      if (!((bus.dig_sel == 2'b10 && bus.seg == 8'h92) || (bus.dig_sel == 2'b01 && bus.seg == 8'hFF))) begin
        n_fail++; $display("FAIL disp_05 c%0d dig_sel/seg got %b/%h want 10/92 or 01/FF", c, bus.dig_sel, bus.seg);
      end
    end
    drive_step(1'b1, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    drive_step(1'b1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.dig_sel !== 2'b10 || bus.seg !== 8'hC0 || bus.hit_led !== 1'b0 || bus.count_bcd !== 8'h00) begin
      n_fail++; $display("FAIL midscan_reset dig/seg/hit/cnt got %b/%h/%b/%h want 10/C0/0/00", bus.dig_sel, bus.seg, bus.hit_led, bus.count_bcd);
    end
  endtask

  initial begin
    bus.tick_en  = 1'b0;
    bus.match_in = 1'b0;
    bus.clr      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_pulse_count();
    test_carry_wrap();
    test_tick_gating();
    test_display();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_count_disp.md
Name: match_count_disp

Overview:
Downstream consumer of the 11010 sequence detector. It takes the detector's match indication and counts detections as a 2-digit BCD value (00-99). It stretches each detection into a visible LED pulse and drives a 2-digit multiplexed 7-segment display on the Cyclone board. Detector and this block share one clock; the slow-rate domain is expressed as a one-cycle enable.

Parameters:
SCAN_DIV, 50000, clk cycles per display digit slot (1 kHz digit rate at 50 MHz); legal range >= 2
HOLD_TICKS, 3, number of tick_en pulses hit_led stays lit after a detection; legal range 1-15

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
tick_en  input  1  one-cycle enable at the detector's step rate (tie 1 in simulation)
match_in  input  1  detector match level (high while the detector sits in its match state)
clr  input  1  synchronous clear of count and overflow
count_bcd  output  8  [7:4] tens, [3:0] ones, BCD
ovf  output  1  sticky flag, set when count wraps 99->00
hit_led  output  1  stretched detection indicator
seg  output  8  segments, active-low, bit7=dp, bits6..0=g..a
dig_sel  output  2  digit enables, active-low; bit0=ones digit, bit1=tens digit

Behaviour:
- Reset (rst=1 at clk edge) forces: count_bcd=8'h00, ovf=0, hit_led=0, hold counter=0, match_prev=0, scan counter=0, active digit=ones, dig_sel=2'b10, seg=8'hC0 (ones digit '0').
- Sampling: match_in is sampled only on cycles with tick_en=1; match_prev updates to match_in on those cycles only.
- Detection event: tick_en=1 && match_in=1 && match_prev=0. A level held high across several ticks counts once. Transitions of match_in between ticks are ignored.
- Count: on a detection event, BCD increment. Ones 9->0 carries into tens. 99->00 wraps and sets ovf=1. count_bcd and ovf are registered and change on the clk edge that samples the event (visible the next cycle).
- clr=1: count_bcd<=00 and ovf<=0. clr takes priority over a simultaneous detection event, and that event is lost. clr does not affect hit_led or the display scan.
- hit_led: driven by a 4-bit hold counter. A detection event loads HOLD_TICKS, and a retrigger while lit reloads it. Otherwise, each tick_en with hold!=0 decrements by 1. hit_led = (hold!=0). Load has priority over decrement in the same cycle.
- Display scan: a free-running counter runs 0..SCAN_DIV-1. On the terminal count it returns to 0 and the active digit toggles. dig_sel and seg are registered, and the digit and pattern update on the same edge.
- seg encoding (active-low, dp off):
  - digits 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90
  - tens digit = 0 is blanked (FF)
  - non-BCD nibble = FF (unreachable, defensive)
- seg always shows the digit of the count_bcd value registered at the moment of update; no tearing across digits within one update.
- rst mid-scan or mid-hold returns to the reset state on the next edge, regardless of tick_en or clr.

Test Plan:
- Reset: assert rst 2 cycles with match_in=1, tick_en=1 -> count_bcd=00, ovf=0, hit_led=0, dig_sel=10, seg=C0. Then release with match_in still 1 -> first tick counts (match_prev=0 after reset), count=01.
- Pulse counting, tick_en=1: drive match_in high for 1 cycle on 3 separate occasions, HOLD_TICKS=3 -> count 01,02,03. hit_led high exactly 3 cycles after each lone pulse. A held 5-cycle high level counts once.
- Carry/wrap: preload to 09 via 9 events, then 1 more -> 8'h10. Continue to 99, then 1 more -> 00 with ovf=1. clr -> 00, ovf=0. clr simultaneous with an event -> 00 (event dropped).
- tick gating: tick_en=1 every 4 cycles, match_in high for 2 cycles between ticks -> no count. match_in high across a tick -> count +1, hit_led lasts 3 ticks (12 cycles). Retrigger at hold=1 reloads to 3.
- Display, SCAN_DIV=4, count=8'h47: dig_sel alternates 10/01 every 4 cycles. seg=F8 with dig_sel=10, seg=99 with dig_sel=01. count=05 -> tens slot seg=FF.
